// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of one shared single-port memory.
// Every access runs IDLE (grant + latch) -> ACCESS (one memory cycle) -> DONE
// (ack held until the granted requester drops req: four-phase handshake).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] address0,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;   // 0 = requester 0 owns the access
  logic                  last_q, last_d;     // requester granted most recently
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  pick;
  logic                  granted_req;

  // On a tie the requester not served last wins; a lone request simply wins.
  assign pick        = (req0 & req1) ? ~last_q : req1;
  assign granted_req = grant_q ? req1 : req0;

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d = pick;
          last_d  = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? address1 : address0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          if (grant_q) rdata1_d = mem_data_in;
          else         rdata0_d = mem_data_in;
        end
        state_d = DONE;
      end
      DONE: begin
        if (!granted_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Memory sees the latched copy, so it holds its last value outside ACCESS.
  assign mem_address      = addr_q;
  assign mem_data_out     = wdata_q;
  assign mem_write_enable = (state_q == ACCESS) & we_q;
  assign ack0             = (state_q == DONE) & ~grant_q;
  assign ack1             = (state_q == DONE) & grant_q;
  assign busy             = (state_q != IDLE);
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized two-requester
// run checked against a transaction-level model (round-robin order, memory
// contents, per-requester read data).
module tb_mem_arbiter;
  localparam int AW      = 10;
  localparam int DW      = 16;
  localparam int RND_CYC = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] address0, address1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out;
  logic          mem_write_enable;
  logic [DW-1:0] mem_data_in;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .address0(address0), .address1(address1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_write_enable(mem_write_enable), .mem_data_in(mem_data_in),
    .busy(busy)
  );

  // Shared memory: preloaded pattern word = addr*25 until first written.
  logic [DW-1:0] mem [1024];
  bit            wr_vld [1024];
  int            n_strobe = 0;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return 16'(a) * 16'd25;
  endfunction

  assign mem_data_in = wr_vld[mem_address] ? mem[mem_address] : init_word(mem_address);

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_address]    <= mem_data_out;
      wr_vld[mem_address] <= 1'b1;
      n_strobe            <= n_strobe + 1;
    end
  end

  // Reference model state
  logic [DW-1:0] model_mem [1024];
  logic [DW-1:0] exp_rd [2];
  logic          last_m;
  bit            hq0 [RND_CYC];
  bit            hq1 [RND_CYC];
  logic          rq [2], tw [2], ak [2];
  logic [AW-1:0] ta [2];
  logic [DW-1:0] td [2];
  bit            seen [2];
  logic          exp_win;
  int            n_wr, stb_base, nstb;
  logic [DW-1:0] phys;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic drive(input int who, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who == 0) begin req0 = r; we0 = w; address0 = a; wdata0 = d; end
    else          begin req1 = r; we1 = w; address1 = a; wdata1 = d; end
  endtask

  task automatic wait_ack(input int who, input int max);
    int n = 0;
    while ((who == 0 ? ack0 : ack1) !== 1'b1 && n < max) begin
      @(negedge clk); n++;
    end
    chk("wait_ack", 32'(who == 0 ? ack0 : ack1), 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy | ack0 | ack1) !== 1'b0 && n < max) begin
      @(negedge clk); n++;
    end
    chk("wait_idle", 32'(busy | ack0 | ack1), 0);
  endtask

  task automatic xact(input int who, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(who, 1'b1, w, a, d);
    wait_ack(who, 8);
    if (w) model_mem[a] = d;
    else   exp_rd[who] = model_mem[a];
    chk("xact_rdata0", 32'(rdata0), 32'(exp_rd[0]));
    chk("xact_rdata1", 32'(rdata1), 32'(exp_rd[1]));
    drive(who, 1'b0, w, a, d);
    wait_idle(8);
  endtask

  // Both requesters read at once; requester 0 is expected first, then 1.
  task automatic tie_round(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    int n = 0;
    drive(0, 1'b1, 1'b0, a0, '0);
    drive(1, 1'b1, 1'b0, a1, '0);
    while ((ack0 | ack1) !== 1'b1 && n < 8) begin
      @(negedge clk); n++;
    end
    chk("tie_first_ack0", 32'(ack0), 1);
    chk("tie_first_ack1", 32'(ack1), 0);
    exp_rd[0] = model_mem[a0];
    chk("tie_rdata0", 32'(rdata0), 32'(exp_rd[0]));
    drive(0, 1'b0, 1'b0, a0, '0);
    wait_ack(1, 8);
    chk("tie_second_ack0", 32'(ack0), 0);
    exp_rd[1] = model_mem[a1];
    chk("tie_rdata1", 32'(rdata1), 32'(exp_rd[1]));
    drive(1, 1'b0, 1'b0, a1, '0);
    wait_idle(8);
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 1024; i++) model_mem[i] = init_word(AW'(i));
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Asynchronous reset before any clock edge
    #2 reset = 1'b0;
    #1;
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(mem_write_enable), 0);
    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_wdata", 32'(mem_data_out), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    chk("rst_rdata1", 32'(rdata1), 0);
    @(negedge clk); reset = 1'b1;

    // Ties from reset: 0 then 1, and again 0 then 1
    tie_round(10'd2, 10'd3);
    tie_round(10'd8, 10'd9);

    // Single read of address 1 (word 0x0019), cycle by cycle
    drive(0, 1'b1, 1'b0, 10'h001, '0);
    @(negedge clk);
    chk("rd_access_addr", 32'(mem_address), 'h001);
    chk("rd_access_busy", 32'(busy), 1);
    chk("rd_access_ack", 32'(ack0), 0);
    chk("rd_access_we", 32'(mem_write_enable), 0);
    @(negedge clk);
    chk("rd_ack", 32'(ack0), 1);
    chk("rd_data", 32'(rdata0), 'h0019);
    exp_rd[0] = 16'h0019;
    @(negedge clk);
    chk("rd_ack_hold", 32'(ack0), 1);
    chk("rd_done_we", 32'(mem_write_enable), 0);
    drive(0, 1'b0, 1'b0, 10'h001, '0);
    @(negedge clk);
    chk("rd_ack_drop", 32'(ack0), 0);
    chk("rd_idle", 32'(busy), 0);

    // Write 0xA5A5 to 0x3FF from requester 1: exactly one strobe
    nstb = 0;
    drive(1, 1'b1, 1'b1, 10'h3FF, 16'hA5A5);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (mem_write_enable) begin
        nstb++;
        chk("wr_addr", 32'(mem_address), 'h3FF);
        chk("wr_data", 32'(mem_data_out), 'hA5A5);
      end
    end
    chk("wr_strobes", nstb, 1);
    chk("wr_ack", 32'(ack1), 1);
    chk("wr_rdata1_kept", 32'(rdata1), 32'(exp_rd[1]));
    model_mem[10'h3FF] = 16'hA5A5;
    drive(1, 1'b0, 1'b1, 10'h3FF, 16'hA5A5);
    wait_idle(8);
    xact(0, 1'b0, 10'h3FF, '0);

    // Requester 1 arrives during requester 0's ACCESS and is held off
    drive(0, 1'b1, 1'b0, 10'd4, '0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 10'd5, '0);
    @(negedge clk);
    chk("ho_ack0", 32'(ack0), 1);
    chk("ho_ack1", 32'(ack1), 0);
    exp_rd[0] = model_mem[4];
    chk("ho_rdata0", 32'(rdata0), 32'(exp_rd[0]));
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("ho_ack1_held", 32'(ack1), 0);
    end
    drive(0, 1'b0, 1'b0, 10'd4, '0);
    @(negedge clk);
    chk("ho_ack0_drop", 32'(ack0), 0);
    chk("ho_ack1_wait", 32'(ack1), 0);
    wait_ack(1, 8);
    exp_rd[1] = model_mem[5];
    chk("ho_rdata1", 32'(rdata1), 32'(exp_rd[1]));
    chk("ho_rdata0_kept", 32'(rdata0), 32'(exp_rd[0]));
    drive(1, 1'b0, 1'b0, 10'd5, '0);
    wait_idle(8);

    // Address changes after grant; access still uses the latched 0x002
    drive(0, 1'b1, 1'b0, 10'h002, '0);
    @(negedge clk);
    address0 = 10'h005;
    #1;
    chk("latch_addr", 32'(mem_address), 'h002);
    @(negedge clk);
    chk("latch_ack", 32'(ack0), 1);
    exp_rd[0] = model_mem[2];
    chk("latch_rdata0", 32'(rdata0), 32'(exp_rd[0]));
    drive(0, 1'b0, 1'b0, 10'h005, '0);
    wait_idle(8);

    // Reset in the middle of a write ACCESS: strobe must vanish at once
    stb_base = n_strobe;
    drive(0, 1'b1, 1'b1, 10'd7, 16'h1234);
    @(negedge clk);
    chk("abort_we_before", 32'(mem_write_enable), 1);
    reset = 1'b0;
    #1;
    chk("abort_we", 32'(mem_write_enable), 0);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk);
    chk("abort_no_strobe", n_strobe - stb_base, 0);
    chk("abort_no_ack", 32'(ack0), 0);
    drive(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    xact(0, 1'b0, 10'd7, '0);

    // Reset while requester 1 holds ack
    drive(1, 1'b1, 1'b0, 10'd6, '0);
    wait_ack(1, 8);
    chk("rdone_rdata1", 32'(rdata1), 32'(model_mem[6]));
    #2 reset = 1'b0;
    #1;
    chk("rdone_ack1", 32'(ack1), 0);
    chk("rdone_busy", 32'(busy), 0);
    chk("rdone_rdata1_clr", 32'(rdata1), 0);
    chk("rdone_addr", 32'(mem_address), 0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    chk("rdone_idle", 32'(busy), 0);
    tie_round(10'd10, 10'd11);

    // Randomized two-requester traffic against the transaction model
    do_reset();
    last_m   = 1'b1;
    n_wr     = 0;
    stb_base = n_strobe;
    hq0[0] = 1'b0; hq0[1] = 1'b0; hq1[0] = 1'b0; hq1[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; tw[i] = 1'b0; ta[i] = '0; td[i] = '0; seen[i] = 1'b1;
    end
    for (int k = 2; k < RND_CYC; k++) begin
      @(negedge clk);
      ak[0] = ack0;
      ak[1] = ack1;
      chk("ack_onehot", 32'(ack0 & ack1), 0);
      chk("we_only_busy", 32'(mem_write_enable & ~busy), 0);
      for (int i = 0; i < 2; i++) begin
        if (ak[i] && !seen[i]) begin
          seen[i] = 1'b1;
          // grant was made at the edge that sampled the requests driven two negedges ago
          exp_win = (hq0[k-2] && hq1[k-2]) ? ~last_m : logic'(hq1[k-2]);
          chk("rr_winner", i, 32'(exp_win));
          last_m = exp_win;
          if (tw[i]) begin
            model_mem[ta[i]] = td[i];
            n_wr++;
          end else begin
            exp_rd[i] = model_mem[ta[i]];
          end
          chk("rnd_rdata0", 32'(rdata0), 32'(exp_rd[0]));
          chk("rnd_rdata1", 32'(rdata1), 32'(exp_rd[1]));
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (rq[i] && ak[i]) begin
          if ($urandom_range(1, 0) == 1) rq[i] = 1'b0;
        end else if (!rq[i] && !ak[i] && k < RND_CYC - 200) begin
          if ($urandom_range(3, 0) == 0) begin
            rq[i]   = 1'b1;
            tw[i]   = 1'($urandom_range(1, 0));
            ta[i]   = AW'($urandom_range(15, 0));
            td[i]   = DW'($urandom);
            seen[i] = 1'b0;
          end
        end
      end
      drive(0, rq[0], tw[0], ta[0], td[0]);
      drive(1, rq[1], tw[1], ta[1], td[1]);
      hq0[k] = rq[0];
      hq1[k] = rq[1];
    end
    wait_idle(20);
    chk("rnd_strobes", n_strobe - stb_base, n_wr);
    for (int a = 0; a < 16; a++) begin
      phys = wr_vld[a] ? mem[a] : init_word(AW'(a));
      chk("rnd_mem", 32'(phys), 32'(model_mem[a]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
